// File: rtl/uart_tx_buffered_pkg.sv
// Shared types and line levels for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uartState_t;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock FIFO with registered full/empty and same-cycle read/write.
// Read data is the head entry, valid whenever empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdEn,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic [AW:0]      count, countNext;
    logic             wrOk, rdOk;

    // A write into a full FIFO still lands when the head leaves in the same cycle.
    assign wrOk   = wrEn && (!full || rdEn);
    assign rdOk   = rdEn && !empty;
    assign rdData = mem[rdPtr];

    always_comb begin
        countNext = count;
        if (wrOk && !rdOk)
            countNext = count + CNT_ONE;
        else if (!wrOk && rdOk)
            countNext = count - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wrOk) wrPtr <= wrPtr + AW'(1);
            if (rdOk) rdPtr <= rdPtr + AW'(1);
            count <= countNext;
            full  <= (countNext == CNT_FULL);
            empty <= (countNext == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wrOk) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter on the baud clock; define UART_PARITY_EN
// to insert an even-parity bit (8E1).
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int BIT_CYCLES    = 1,
    parameter int CAPTURE_DELAY = 1
) (
    input  logic       clkBaud,
    input  logic       rstN,
    input  logic       init,
    input  logic [7:0] datotx,
    output logic       tx,
    output logic       busy,
    output logic       empty,
    output logic       full,
    output logic       overflow
);
    localparam int CW = $clog2(BIT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    uartState_t           state;
    logic [CW-1:0]        cnt;
    logic [2:0]           bitIdx;
    logic [DATA_BITS-1:0] shift, rdData;
    logic                 wrEn, pop, bitDone, txNext;
`ifdef UART_PARITY_EN
    logic                 parBit;
`endif

    generate
        if (CAPTURE_DELAY == 0) begin : gCapNow
            assign wrEn = init;
        end else begin : gCapDly
            logic initD;
            always_ff @(posedge clkBaud or negedge rstN) begin
                if (!rstN) initD <= 1'b0;
                else       initD <= init;
            end
            assign wrEn = initD;
        end
    endgenerate

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) uFifo (
        .clk    (clkBaud),
        .rstN   (rstN),
        .wrEn   (wrEn),
        .wrData (datotx),
        .rdEn   (pop),
        .rdData (rdData),
        .full   (full),
        .empty  (empty)
    );

    assign bitDone = (cnt == CNT_LAST);
    // Popping in the last stop cycle chains frames with no idle gap.
    assign pop     = !empty && ((state == IDLE) || (state == STOP && bitDone));

    always_ff @(posedge clkBaud or negedge rstN) begin
        if (!rstN)                      overflow <= 1'b0;
        else if (wrEn && full && !pop)  overflow <= 1'b1;
    end

    always_comb begin
        case (state)
            IDLE:    txNext = IDLE_LEVEL;
            START:   txNext = START_LEVEL;
            DATA:    txNext = shift[0];
`ifdef UART_PARITY_EN
            PARITY:  txNext = parBit;
`endif
            default: txNext = STOP_LEVEL;
        endcase
    end

    // tx/busy follow the state one cycle later, so the line never sees decode glitches.
    always_ff @(posedge clkBaud or negedge rstN) begin
        if (!rstN) begin
            state  <= IDLE;
            cnt    <= '0;
            bitIdx <= '0;
            shift  <= '0;
            tx     <= IDLE_LEVEL;
            busy   <= 1'b0;
`ifdef UART_PARITY_EN
            parBit <= 1'b0;
`endif
        end else begin
            tx   <= txNext;
            busy <= (state != IDLE);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pop) begin
                        shift <= rdData;
`ifdef UART_PARITY_EN
                        parBit <= ^rdData;
`endif
                        state <= START;
                    end
                end
                START: begin
                    if (bitDone) begin
                        cnt    <= '0;
                        bitIdx <= '0;
                        state  <= DATA;
                    end else cnt <= cnt + CW'(1);
                end
                DATA: begin
                    if (bitDone) begin
                        cnt    <= '0;
                        shift  <= {1'b0, shift[DATA_BITS-1:1]};
                        bitIdx <= bitIdx + 3'd1;
                        if (bitIdx == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else cnt <= cnt + CW'(1);
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (bitDone) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else cnt <= cnt + CW'(1);
                end
`endif
                STOP: begin
                    if (bitDone) begin
                        cnt <= '0;
                        if (pop) begin
                            shift <= rdData;
`ifdef UART_PARITY_EN
                            parBit <= ^rdData;
`endif
                            state <= START;
                        end else state <= IDLE;
                    end else cnt <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three configurations, line samples decoded by a software UART.
module tb_uart_tx_buffered;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rstN;
    logic [2:0] init;
    logic [7:0] dat [3];
    logic [2:0] tx, busy, empty, full, ovf;

    int errors = 0;
    int checks = 0;

    bit         rec = 1'b0;
    bit         s0[$], s1[$], s2[$];
    logic [7:0] dec[$];
    int         starts[$];
    logic [7:0] expq[$];
    logic [7:0] bytesB [6];
    logic [7:0] b8;
    int         occ;
    bit         ovfExp, popNow;

    always #5 clk = ~clk;

    uart_tx_buffered #(.DEPTH(16), .BIT_CYCLES(1), .CAPTURE_DELAY(1)) dutA (
        .clkBaud(clk), .rstN(rstN), .init(init[0]), .datotx(dat[0]), .tx(tx[0]),
        .busy(busy[0]), .empty(empty[0]), .full(full[0]), .overflow(ovf[0]));
    uart_tx_buffered #(.DEPTH(4), .BIT_CYCLES(4), .CAPTURE_DELAY(1)) dutB (
        .clkBaud(clk), .rstN(rstN), .init(init[1]), .datotx(dat[1]), .tx(tx[1]),
        .busy(busy[1]), .empty(empty[1]), .full(full[1]), .overflow(ovf[1]));
    uart_tx_buffered #(.DEPTH(16), .BIT_CYCLES(1), .CAPTURE_DELAY(0)) dutC (
        .clkBaud(clk), .rstN(rstN), .init(init[2]), .datotx(dat[2]), .tx(tx[2]),
        .busy(busy[2]), .empty(empty[2]), .full(full[2]), .overflow(ovf[2]));

    always @(negedge clk) begin
        if (rec) begin
            s0.push_back(tx[0]);
            s1.push_back(tx[1]);
            s2.push_back(tx[2]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level of frame bit j for byte b (start, 8 data LSB first, [parity], stop).
    function automatic logic frameBit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (FB == 11 && j == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic clearRec();
        s0.delete(); s1.delete(); s2.delete();
    endtask

    // Software receiver: scans per-cycle samples for start bits and reads each bit mid-cell.
    task automatic decode(input bit s[$], input int bc, input string tag);
        int i, mid;
        logic [7:0] b;
        dec.delete();
        starts.delete();
        i = 0;
        while (i < s.size()) begin
            if (s[i] == 1'b0) begin
                if (i + FB*bc > s.size()) begin
                    chk({tag, " truncated frame"}, s.size(), i + FB*bc);
                    break;
                end
                mid = i + bc/2;
                chk({tag, " start"}, s[mid], 0);
                b = '0;
                for (int j = 0; j < 8; j++) b[j] = s[mid + (j+1)*bc];
`ifdef UART_PARITY_EN
                chk({tag, " parity"}, s[mid + 9*bc], ^b);
`endif
                chk({tag, " stop"}, s[mid + (FB-1)*bc], 1);
                dec.push_back(b);
                starts.push_back(i);
                i += FB*bc;
            end else i++;
        end
    endtask

    task automatic cmpBytes(input string tag, input logic [7:0] e[$]);
        chk({tag, " frames"}, dec.size(), e.size());
        for (int i = 0; i < dec.size() && i < e.size(); i++)
            chk({tag, " byte"}, dec[i], e[i]);
    endtask

    task automatic contiguous(input string tag, input int bc);
        for (int i = 1; i < starts.size(); i++)
            chk({tag, " spacing"}, starts[i] - starts[i-1], FB*bc);
    endtask

    // Consecutive init pulses on a CAPTURE_DELAY=1 instance; data follows one cycle later.
    task automatic burst(input int k, input logic [7:0] q[$]);
        for (int i = 0; i <= q.size(); i++) begin
            init[k] = (i < q.size());
            if (i > 0) dat[k] = q[i-1];
            tick();
        end
        init[k] = 1'b0;
    endtask

    initial begin
        rstN = 1'b0;
        init = '0;
        for (int k = 0; k < 3; k++) dat[k] = '0;
        repeat (3) tick();
        chk("reset tx", tx, 3'b111);
        chk("reset busy", busy, 3'b000);
        chk("reset empty", empty, 3'b111);
        chk("reset full", full, 3'b000);
        chk("reset overflow", ovf, 3'b000);
        rstN = 1'b1;
        repeat (3) tick();
        chk("idle tx", tx, 3'b111);

        // Single byte with exact latency: capture C, pop C+1, tx falls C+2.
        init[0] = 1'b1; tick();
        init[0] = 1'b0; dat[0] = 8'h33; tick();
        chk("T1 capture empty", empty[0], 0);
        chk("T1 capture tx", tx[0], 1);
        tick();
        chk("T1 pop empty", empty[0], 1);
        chk("T1 pop busy", busy[0], 0);
        chk("T1 pop tx", tx[0], 1);
        for (int j = 0; j < FB; j++) begin
            tick();
            chk("T1 tx bit", tx[0], frameBit(8'h33, j));
            chk("T1 busy", busy[0], 1);
        end
        tick();
        chk("T1 after tx", tx[0], 1);
        chk("T1 after busy", busy[0], 0);

        // Two bytes 16 cycles apart: two separate frames.
        clearRec(); rec = 1'b1;
        burst(0, '{8'h33});
        repeat (14) tick();
        burst(0, '{8'hB1});
        repeat (30) tick();
        rec = 1'b0;
        decode(s0, 1, "T2");
        cmpBytes("T2", '{8'h33, 8'hB1});
        if (starts.size() == 2) chk("T2 gap", starts[1] - starts[0], 16);

        // Parity patterns back to back, then a random burst; frames must be contiguous.
        clearRec(); rec = 1'b1;
        burst(0, '{8'h31, 8'h30});
        repeat (2*FB + 8) tick();
        rec = 1'b0;
        decode(s0, 1, "T5");
        cmpBytes("T5", '{8'h31, 8'h30});
        contiguous("T5", 1);

        expq.delete();
        for (int i = 0; i < 8; i++) expq.push_back(8'($urandom));
        clearRec(); rec = 1'b1;
        burst(0, expq);
        repeat (8*FB + 10) tick();
        rec = 1'b0;
        decode(s0, 1, "RND");
        cmpBytes("RND", expq);
        contiguous("RND", 1);
        chk("RND overflow", ovf[0], 0);

        // Overflow: six back-to-back bytes into a 4-deep FIFO with 4-cycle bits.
        for (int i = 0; i < 6; i++) bytesB[i] = 8'($urandom);
        expq.delete();
        occ = 0; ovfExp = 1'b0;
        clearRec(); rec = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            init[1] = (i < 6);
            if (i > 0 && i <= 6) dat[1] = bytesB[i-1];
            tick();
            popNow = (i == 2);
            if (i >= 1 && i <= 6) begin
                if (occ < 4 || popNow) begin
                    expq.push_back(bytesB[i-1]);
                    occ++;
                end else ovfExp = 1'b1;
            end
            if (popNow) occ--;
            chk("OVF full", full[1], occ == 4);
            chk("OVF overflow", ovf[1], ovfExp);
            chk("OVF empty", empty[1], occ == 0);
        end
        init[1] = 1'b0;
        repeat (5*FB*4 + 20) tick();
        rec = 1'b0;
        decode(s1, 4, "OVF");
        cmpBytes("OVF", expq);
        contiguous("OVF", 4);
        chk("OVF sticky", ovf[1], 1);
        chk("OVF drained", empty[1], 1);

        // Zero capture delay: data is sampled with init, later changes are ignored.
        clearRec(); rec = 1'b1;
        init[2] = 1'b1; dat[2] = 8'hAA; tick();
        init[2] = 1'b0; dat[2] = 8'h55; tick();
        repeat (FB + 8) tick();
        rec = 1'b0;
        decode(s2, 1, "CD0");
        cmpBytes("CD0", '{8'hAA});

        // Reset during data bit 3 of 0x33 with a second byte still queued.
        b8 = 8'($urandom);
        burst(0, '{8'h33, b8});
        repeat (5) tick();
        chk("RST bit3", tx[0], frameBit(8'h33, 4));
        chk("RST busy before", busy[0], 1);
        #2 rstN = 1'b0;
        #1;
        chk("RST tx", tx[0], 1);
        chk("RST busy", busy[0], 0);
        chk("RST empty", empty[0], 1);
        tick();
        #2 rstN = 1'b1;
        clearRec(); rec = 1'b1;
        repeat (30) tick();
        rec = 1'b0;
        chk("RST empty after", empty[0], 1);
        decode(s0, 1, "RST");
        expq.delete();
        cmpBytes("RST", expq);
        chk("RST overflow", ovf[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Serial transmitter for the status link. Accepts bytes from the packet encoder via a one-cycle `init` strobe plus an 8-bit data bus, buffers them in a small FIFO, and shifts them out LSB-first as asynchronous UART frames on `tx`. It runs on the baud clock shared with the encoder and drives the board's TX pin directly.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `BIT_CYCLES`, 1: `clkBaud` cycles per serial bit; at least 1.
- `CAPTURE_DELAY`, 1: cycles after `init` at which `datotx` is sampled; 0 or 1.

- `clkBaud` input 1: baud clock; all logic is on its rising edge.
- `rstN` input 1: asynchronous, active-low reset.
- `init` input 1: one-cycle byte strobe from the encoder.
- `datotx` input 8: byte to send; valid `CAPTURE_DELAY` cycles after `init`.
- `tx` output 1: serial line; idles high.
- `busy` output 1: high while a frame is on the line.
- `empty` output 1: FIFO holds no bytes.
- `full` output 1: FIFO holds `DEPTH` bytes.
- `overflow` output 1: sticky; a byte was dropped.

## Operation
- **Capture.** `init` passes through a `CAPTURE_DELAY`-deep strobe pipe. When the delayed strobe is high, `datotx` is written into the FIFO. Consecutive `init` pulses give consecutive captures.
- **Full FIFO.**
  - Write while full with no pop in the same cycle: the byte is dropped and `overflow` is set.
  - Write and pop in the same cycle: both take effect and the count is unchanged.
- **Empty FIFO.** A pop while empty never occurs; the FSM pops only when `empty` is 0.
- **FSM states and transitions:**
  - IDLE: `tx`=1. If `!empty`, pop the head byte into the shift register and go to START.
  - START: `tx`=0 for `BIT_CYCLES` cycles, then go to DATA.
  - DATA: `tx` = shift[0], bits 0..7, `BIT_CYCLES` cycles each. A 3-bit bit index and a bit-cycle counter (width clog2(`BIT_CYCLES`)+1) run here.
  - PARITY: present only with the macro (see Configuration); then go to STOP.
  - STOP: `tx`=1 for `BIT_CYCLES` cycles. In the last stop cycle, if `!empty`, pop and go to START (no idle gap); otherwise go to IDLE.
- **Outputs.**
  - `busy` is 1 in every state except IDLE.
  - `tx` is registered and glitch-free.
- **Reset values.** `tx`=1, `busy`=0, `empty`=1, `full`=0, `overflow`=0, FSM=IDLE, FIFO pointers 0.
- **Reset mid-frame.** `tx` returns high asynchronously, the frame is aborted, and FIFO contents are discarded.
- **Overflow.** `overflow` is cleared only by reset.

## Timing
- Capture edge C is `init` edge + `CAPTURE_DELAY`.
- With the FSM in IDLE and the FIFO empty:
  - pop occurs at C+1;
  - `tx` falls at C+2;
  - `busy` rises at C+2.
- Frame length is 10×`BIT_CYCLES` cycles, or 11×`BIT_CYCLES` with parity.
- Back-to-back frames are contiguous: the next start bit directly follows the stop bit.
- `full` and `empty` are registered and reflect the count after each edge.
- Sustained rate is one byte per frame length. The producer must not exceed it by more than `DEPTH` bytes per burst.

## Configuration
- `UART_PARITY_EN` defined:
  - a PARITY state is inserted between DATA and STOP;
  - `tx` = XOR of the 8 data bits (even parity);
  - frame is 11 bits.
- `UART_PARITY_EN` undefined: the PARITY state and its logic are absent, and the frame is 10 bits (8N1).

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - `DATA_BITS`=8, `START_LEVEL`=0, `STOP_LEVEL`=1, `IDLE_LEVEL`=1.
- Sub-module `sync_fifo`, parameterised by width and `DEPTH`, with async active-low reset, provides `full`, `empty` and same-cycle read/write.
- Capture pipe, FSM and shift register live in the top module.

## Test plan
- **Single byte, defaults.** Reset, `init` pulse, 0x33 on `datotx` one cycle later → `tx` = 0,1,1,0,0,1,1,0,0,1 starting two cycles after capture; `busy` high exactly 10 cycles.
- **Back-to-back.** 0x33 then 0xB1 with `init` pulses 16 cycles apart → two frames. Second frame bits: 0,1,0,0,0,1,1,0,1,1. `tx` goes idle high between frames.
- **Overflow.** `DEPTH`=4, `BIT_CYCLES`=4, 6 bytes on consecutive `init` cycles →
  - `full` after the 4th write (or 5th if the first byte was popped);
  - dropped byte sets `overflow`=1;
  - `tx` emits only the bytes accepted into the FIFO, in write order.
- **Reset mid-frame.** Assert `rstN`=0 during data bit 3 of 0x33 → `tx`=1 and `busy`=0 immediately. After release, `empty`=1 and no further frame is sent.
- **Parity.** With `UART_PARITY_EN`, send 0x31 → frame 0,1,0,0,0,1,1,0,0,1,1 (parity bit 1). Send 0x30 → parity bit 0.
- **Capture delay.** `CAPTURE_DELAY`=0, change `datotx` from 0xAA to 0x55 in the cycle after `init` → the frame carries 0xAA.
